mul16_seq: RTL and testbench

//   Multi-cycle shift-and-add multiplier, 16x16 -> 32 bits. Sits directly downstream of the
//   16-bit bitwise AND stage. Each cycle forms one partial product, multiplicand & {16{mplier[0]}},
//   and accumulates it. Start/done handshake to the ALU/control path; one product in flight.

---
 rtl/mul16_seq.sv | 101 ++++++++++
 tb/tb_mul16_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mul16_seq.sv
// Sequential 16x16 -> 32 shift-and-add multiplier with a start/done handshake.
// It forms one partial product per cycle and keeps only one product in flight.
module mul16_seq #(
  parameter bit SIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a16,
  input  logic [15:0] b16,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] p32
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_mcand, r_mplier;
  logic [31:0] r_acc, r_p32;
  logic [3:0]  r_cnt;
  logic        r_neg;

  logic        w_accept, w_last;
  logic [15:0] w_a_abs, w_b_abs, w_pp;
  logic [16:0] w_sum;
  logic [31:0] w_acc_nxt, w_prod;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == 4'd15) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: the handshake outputs depend only on registered state
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (r_state)
      S_IDLE:  ready = 1'b1;
      S_RUN:   busy  = 1'b1;
      S_DONE:  begin ready = 1'b1; done = 1'b1; end
      default: ready = 1'b0;
    endcase
  end

  assign w_accept = ready & start;
  assign w_last   = busy & (r_cnt == 4'd15);

  // Magnitudes for signed mode; 0x8000 maps onto itself and is read as unsigned 32768
  assign w_a_abs = (SIGNED && a16[15]) ? (~a16 + 16'd1) : a16;
  assign w_b_abs = (SIGNED && b16[15]) ? (~b16 + 16'd1) : b16;

  assign w_pp      = r_mcand & {16{r_mplier[0]}};
  assign w_sum     = {1'b0, r_acc[31:16]} + {1'b0, w_pp};
  assign w_acc_nxt = {w_sum, r_acc[15:1]};
  assign w_prod    = r_neg ? (~w_acc_nxt + 32'd1) : w_acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_p32    <= '0;
    end else if (w_accept) begin
      r_mcand  <= w_a_abs;
      r_mplier <= w_b_abs;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= SIGNED ? (a16[15] ^ b16[15]) : 1'b0;
    end else if (busy) begin
      r_acc    <= w_acc_nxt;
      r_mplier <= {1'b0, r_mplier[15:1]};
      r_cnt    <= r_cnt + 4'd1;
      // The product register moves only on entry to DONE, so it is never seen half-built
      if (w_last) r_p32 <= w_prod;
    end
  end

  assign p32 = r_p32;

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: an unsigned and a signed instance share the stimulus,
// and each result is compared with a plain-arithmetic product model.
module tb_mul16_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] a16, b16;
  logic        ready_u, busy_u, done_u, ready_s, busy_s, done_s;
  logic [31:0] p_u, p_s;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_pu = '0, exp_ps = '0;

  always #5 clk = ~clk;

  mul16_seq #(.SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start), .a16(a16), .b16(b16),
    .ready(ready_u), .busy(busy_u), .done(done_u), .p32(p_u)
  );

  mul16_seq #(.SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start), .a16(a16), .b16(b16),
    .ready(ready_s), .busy(busy_s), .done(done_s), .p32(p_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mdl_u(input logic [15:0] a, input logic [15:0] b);
    longint unsigned x;
    x = longint'(a) * longint'(b);
    return x[31:0];
  endfunction

  function automatic logic [31:0] mdl_s(input logic [15:0] a, input logic [15:0] b);
    longint x;
    x = longint'($signed(a)) * longint'($signed(b));
    return x[31:0];
  endfunction

  function automatic logic [31:0] flags();
    return {26'd0, ready_u, busy_u, done_u, ready_s, busy_s, done_s};
  endfunction

  // Entered at a negedge with start/a16/b16 already driven for the accepting edge.
  // Leaves at the negedge of the DONE cycle, optionally presenting the next request there.
  task automatic run(input logic [15:0] a, input logic [15:0] b, input bit scramble,
                     input bit chain, input logic [15:0] na, input logic [15:0] nb);
    logic [31:0] eu, es;
    eu = mdl_u(a, b);
    es = mdl_s(a, b);
    chk("accept_ready", flags() & 32'h24, 32'h24);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("run_flags", flags(), 32'h12);
      chk("run_hold_u", p_u, exp_pu);
      chk("run_hold_s", p_s, exp_ps);
      if (scramble) begin
        start = 1'b1;
        a16   = 16'($urandom);
        b16   = 16'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("done_flags", flags(), 32'h2D);
    chk("prod_u", p_u, eu);
    chk("prod_s", p_s, es);
    exp_pu = eu;
    exp_ps = es;
    if (chain) begin
      start = 1'b1;
      a16   = na;
      b16   = nb;
    end else begin
      start = 1'b0;
    end
  endtask

  // From the DONE negedge: go idle for a cycle, then issue a fresh request.
  task automatic go(input logic [15:0] a, input logic [15:0] b, input bit scramble);
    start = 1'b0;
    @(negedge clk);
    chk("idle_flags", flags(), 32'h24);
    chk("idle_hold_u", p_u, exp_pu);
    start = 1'b1;
    a16   = a;
    b16   = b;
    run(a, b, scramble, 1'b0, 16'd0, 16'd0);
  endtask

  initial begin
    logic [15:0] ra, rb, na, nb;
    rst = 1'b1; start = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    chk("rst_flags", flags(), 32'h24);
    chk("rst_p_u", p_u, 32'h0);
    chk("rst_p_s", p_s, 32'h0);
    // rst must win over a simultaneous start
    start = 1'b1; a16 = 16'd3; b16 = 16'd5;
    @(negedge clk);
    chk("rst_over_start", flags(), 32'h24);
    rst = 1'b0;

    // Directed products
    run(16'd3, 16'd5, 1'b0, 1'b0, 16'd0, 16'd0);
    chk("t1_3x5", p_u, 32'h0000000F);
    go(16'hFFFF, 16'hFFFF, 1'b0);
    chk("t2_ffff_sq_u", p_u, 32'hFFFE0001);
    chk("t2_ffff_sq_s", p_s, 32'h00000001);
    go(16'h0000, 16'h1234, 1'b0);
    chk("t2_zero", p_u, 32'h0);

    // Operands changed and start held during RUN are ignored
    go(16'h1234, 16'h00AB, 1'b1);
    chk("t3_held", p_u, 32'h000C28BC);

    // Reset in the middle of RUN
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a16 = 16'h7777; b16 = 16'h3333;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_rst_flags", flags(), 32'h24);
    chk("t4_rst_p_u", p_u, 32'h0);
    chk("t4_rst_p_s", p_s, 32'h0);
    exp_pu = '0; exp_ps = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t4_no_done", flags(), 32'h24);
    end
    start = 1'b1; a16 = 16'd11; b16 = 16'd13;
    run(16'd11, 16'd13, 1'b0, 1'b0, 16'd0, 16'd0);
    chk("t4_after", p_u, 32'd143);

    // Back-to-back: next request presented during the DONE cycle
    go(16'd3, 16'd5, 1'b0);
    start = 1'b1; a16 = 16'd3; b16 = 16'd5;
    // already presented by go's tail; chain 7*9 from this DONE
    start = 1'b1; a16 = 16'd7; b16 = 16'd9;
    run(16'd7, 16'd9, 1'b0, 1'b0, 16'd0, 16'd0);
    chk("t5_7x9", p_u, 32'h0000003F);

    // Signed corner cases
    go(16'hFFFE, 16'h0003, 1'b0);
    chk("t6_m2x3", p_s, 32'hFFFFFFFA);
    go(16'h8000, 16'h8000, 1'b0);
    chk("t6_min_sq", p_s, 32'h40000000);
    go(16'h8000, 16'h0001, 1'b0);
    chk("t6_min_x1", p_s, 32'hFFFF8000);

    // Randomized, with random chaining from DONE
    start = 1'b0;
    @(negedge clk);
    ra = 16'($urandom); rb = 16'($urandom);
    start = 1'b1; a16 = ra; b16 = rb;
    for (int i = 0; i < 40; i++) begin
      bit ch;
      ch = ($urandom_range(0, 1) == 1) || (i == 39);
      na = 16'($urandom); nb = 16'($urandom);
      if (i == 39) ch = 1'b0;
      run(ra, rb, ($urandom_range(0, 3) == 0), ch, na, nb);
      if (!ch) begin
        @(negedge clk);
        chk("rnd_idle", flags(), 32'h24);
        start = 1'b1; a16 = na; b16 = nb;
      end
      ra = na; rb = nb;
    end
    start = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
